vram_port_arbiter: RTL and testbench
====================================

Name: vram_port_arbiter

Overview:
- Shares one single-port frame-buffer RAM between the VGA pixel-fetch path (display) and a host access port (pattern loader / debug writer).
- Display reads have absolute priority so the raster never stalls. Host reads and writes are granted only in cycles where the display is not requesting, which in practice means during blanking.
- Routes the RAM's 1-cycle-latency read data back to the correct requester.
- Flags host starvation.

Parameters:
- ADDR_W, 19, RAM word address width (covers 800x600 = 480000 pixels).
- DATA_W, 6, pixel word width (2b red, 2b green, 2b blue).
- MAX_WAIT, 1040, consecutive refused host cycles before the starvation pulse (one 50 MHz line).

Ports:
- clk  in  1  50 MHz pixel clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- disp_req  in  1  display read request this cycle.
- disp_addr  in  ADDR_W  display read address.
- disp_valid  out  1  display read data valid (1 cycle after disp_req).
- disp_data  out  DATA_W  display read data.
- host_valid  in  1  host request pending.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_ready  out  1  host request accepted this cycle.
- host_rvalid  out  1  host read data valid.
- host_rdata  out  DATA_W  host read data.
- host_starve  out  1  one-cycle pulse on starvation.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en & ~mem_we.

Behaviour:
- The arbitration decision is combinational within the cycle.
  - disp_req=1: mem_en=1, mem_we=0, mem_addr=disp_addr, host_ready=0.
  - else host_valid=1: mem_en=1, mem_we=host_we, mem_addr=host_addr, mem_wdata=host_wdata, host_ready=1.
  - else mem_en=0, mem_we=0.
- mem_addr and mem_wdata are don't-care when mem_en=0. Drive them as 0 so the bench can compare them.
- host_ready depends only on disp_req, host_valid and rst. It never depends on host_ready itself, and it is never registered.
- Host handshake: a transfer occurs when host_valid & host_ready. The host holds its inputs stable until accepted. A write completes in the accept cycle.
- Return routing uses a registered 2-bit tag {disp_pend, host_pend}, set on the issuing cycle:
  - next cycle disp_valid=disp_pend, host_rvalid=host_pend;
  - disp_data and host_rdata are mem_rdata when the respective valid is high, else 0;
  - both tags are never set together.
- Read latency is exactly 1 cycle for both requesters. Back-to-back reads sustain 1 per cycle.
- Starvation counter (width clog2(MAX_WAIT+1)):
  - increments each cycle host_valid=1 and host_ready=0;
  - clears when host_valid=0 or on accept;
  - host_starve pulses for exactly one cycle when the counter reaches MAX_WAIT;
  - the counter then saturates at MAX_WAIT, with no further pulses until it is cleared.
- Reset (rst=1), with effect in the same cycle:
  - mem_en=0, mem_we=0, host_ready=0;
  - tags, counter and host_starve cleared, so disp_valid=0 and host_rvalid=0 from the next cycle;
  - a read issued the cycle before reset is discarded: no valid is produced.
- Simultaneous disp_req and host_valid: display wins. The host's wait counter increments.
- Host write followed immediately by a display read of the same address: the display read returns the new data, because RAM write-then-read ordering is preserved.

Test Plan:
- rst=1 for 3 cycles with disp_req=1 and host_valid=1 -> mem_en=0, host_ready=0; disp_valid=0 and host_rvalid=0 through the first post-reset cycle.
- host_valid=1, host_we=1, addr=0x00010, wdata=6'b110011, disp_req=0 -> host_ready=1 the same cycle, mem_we=1, mem_addr=0x00010. A following host read of 0x00010 -> host_rvalid=1 one cycle later with host_rdata=6'b110011.
- disp_req held 1 for 800 cycles (addr 0..799) while host_valid=1 -> host_ready=0 throughout. disp_valid is high for cycles 1..800 with data matching preloaded RAM. The host is accepted in the first cycle disp_req=0.
- host_valid=1 with disp_req=1 for 1100 cycles, MAX_WAIT=1040 -> host_starve is a single pulse after the 1040th refused cycle, with no second pulse. The counter resets after acceptance.
- Interleaved requests disp, host-read, disp on consecutive cycles -> disp_valid, host_rvalid, disp_valid on the following three cycles, each carrying the correct mem_rdata. The other valid stays low and its data stays 0.
- Host read accepted, then rst asserted the next cycle -> host_rvalid stays 0 and no stale data appears.

Source files
------------

// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: shares one single-port VRAM between the display fetch path (absolute priority)
// and a host port, routes 1-cycle read data back by tag and flags host starvation.
module vram_port_arbiter #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 6,
  parameter int MAX_WAIT = 1040
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req_i,
  input  logic [ADDR_W-1:0] disp_addr_i,
  output logic              disp_valid_o,
  output logic [DATA_W-1:0] disp_data_o,
  input  logic              host_valid_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_ready_o,
  output logic              host_rvalid_o,
  output logic [DATA_W-1:0] host_rdata_o,
  output logic              host_starve_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic          disp_go, host_go;
  logic          disp_pend_q, host_pend_q, starve_q;
  logic [CW-1:0] wait_q, wait_d;
  always_comb begin
    disp_go       = ~rst & disp_req_i;
    host_go       = ~rst & ~disp_req_i & host_valid_i;
    mem_en_o      = disp_go | host_go;
    mem_we_o      = host_go & host_we_i;
    mem_addr_o    = disp_go ? disp_addr_i : host_go ? host_addr_i : '0;
    mem_wdata_o   = host_go ? host_wdata_i : '0;
    host_ready_o  = host_go;
    // Gating by rst discards a read issued just before reset
    disp_valid_o  = ~rst & disp_pend_q;
    host_rvalid_o = ~rst & host_pend_q;
    disp_data_o   = disp_valid_o ? mem_rdata_i : '0;
    host_rdata_o  = host_rvalid_o ? mem_rdata_i : '0;
    host_starve_o = ~rst & starve_q;
    wait_d        = (~host_valid_i | host_go) ? '0 :
                    (wait_q == CW'(MAX_WAIT)) ? wait_q : wait_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_pend_q <= 1'b0;
      host_pend_q <= 1'b0;
      wait_q      <= '0;
      starve_q    <= 1'b0;
    end else begin
      disp_pend_q <= disp_go;
      host_pend_q <= host_go & ~host_we_i;
      wait_q      <= wait_d;
      starve_q    <= (wait_d == CW'(MAX_WAIT)) && (wait_q != CW'(MAX_WAIT));
    end
  end
endmodule

// File: tb/tb_vram_port_arbiter.sv
// tb_vram_port_arbiter: directed plus random stimulus against a memory-level reference model;
// a negedge monitor pops expected read returns from per-requester scoreboards.
module tb_vram_port_arbiter;
  localparam int AW = 19, DW = 6, MW = 1040, DEPTH = 2048;
  logic clk = 1'b0, rst = 1'b1;
  logic disp_req = 1'b0, disp_valid;
  logic [AW-1:0] disp_addr = '0, host_addr = '0, mem_addr;
  logic [DW-1:0] disp_data, host_wdata = '0, host_rdata, mem_wdata, mem_rdata = '0;
  logic host_valid = 1'b0, host_we = 1'b0, host_ready, host_rvalid, host_starve, mem_en, mem_we;
  always #5 clk = ~clk;

  vram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .disp_req_i(disp_req), .disp_addr_i(disp_addr), .disp_valid_o(disp_valid), .disp_data_o(disp_data),
    .host_valid_i(host_valid), .host_we_i(host_we), .host_addr_i(host_addr), .host_wdata_i(host_wdata),
    .host_ready_o(host_ready), .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata),
    .host_starve_o(host_starve),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  // The external single-port RAM the arbiter drives
  logic [DW-1:0] ram [0:DEPTH-1];
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) ram[mem_addr[10:0]] <= mem_wdata;
      else mem_rdata <= ram[mem_addr[10:0]];
    end

  // Reference model: plain memory image plus expected returns keyed by due cycle
  typedef struct { int due; logic [DW-1:0] d; } item_t;
  item_t dq[$], hq[$];
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  int cyc = 0, n_cmp = 0, n_bad = 0, wait_n = 0;
  logic starve_nxt = 1'b0, acc = 1'b0;
  logic e_en, e_we, e_rdy, e_st;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd;
  logic h_v = 1'b0, h_we = 1'b0;
  logic [AW-1:0] h_a = '0;
  logic [DW-1:0] h_wd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic dr, input logic [AW-1:0] da);
    @(posedge clk);
    #1;
    cyc++;
    rst = r; disp_req = dr; disp_addr = da;
    host_valid = h_v; host_we = h_we; host_addr = h_a; host_wdata = h_wd;
    if (r) begin
      while (dq.size() > 0 && dq[$].due == cyc) dq.pop_back();
      while (hq.size() > 0 && hq[$].due == cyc) hq.pop_back();
      {e_en, e_we, e_rdy, e_st, acc, starve_nxt} = '0;
      e_addr = '0; e_wd = '0; wait_n = 0;
    end else begin
      e_st = starve_nxt;
      acc = h_v && !dr;
      e_en = dr || h_v;
      e_we = acc && h_we;
      e_rdy = acc;
      e_addr = dr ? da : (h_v ? h_a : '0);
      e_wd = acc ? h_wd : '0;
      if (dr) dq.push_back('{cyc + 1, ref_mem[da[10:0]]});
      else if (acc) begin
        if (h_we) ref_mem[h_a[10:0]] = h_wd;
        else hq.push_back('{cyc + 1, ref_mem[h_a[10:0]]});
      end
      wait_n = (h_v && dr) ? wait_n + 1 : 0;
      starve_nxt = (wait_n == MW);
    end
  endtask

  always @(negedge clk)
    if (cyc > 0) begin
      chk("mem_en", 32'(mem_en), 32'(e_en));
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
      chk("host_ready", 32'(host_ready), 32'(e_rdy));
      chk("host_starve", 32'(host_starve), 32'(e_st));
      if (dq.size() > 0 && dq[0].due == cyc) begin
        chk("disp_valid", 32'(disp_valid), 32'd1);
        chk("disp_data", 32'(disp_data), 32'(dq[0].d));
        void'(dq.pop_front());
      end else begin
        chk("disp_valid", 32'(disp_valid), 32'd0);
        chk("disp_data", 32'(disp_data), 32'd0);
      end
      if (hq.size() > 0 && hq[0].due == cyc) begin
        chk("host_rvalid", 32'(host_rvalid), 32'd1);
        chk("host_rdata", 32'(host_rdata), 32'(hq[0].d));
        void'(hq.pop_front());
      end else begin
        chk("host_rvalid", 32'(host_rvalid), 32'd0);
        chk("host_rdata", 32'(host_rdata), 32'd0);
      end
    end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = DW'($urandom);
      ref_mem[i] = ram[i];
    end
    // Reset with both requesters active
    h_v = 1'b1; h_we = 1'b0; h_a = 19'd9;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 19'd4);
    h_v = 1'b0;
    step(1'b0, 1'b0, '0);
    // Host write then host read of the same word
    h_v = 1'b1; h_we = 1'b1; h_a = 19'h00010; h_wd = 6'b110011;
    step(1'b0, 1'b0, '0);
    h_we = 1'b0;
    step(1'b0, 1'b0, '0);
    h_v = 1'b0;
    step(1'b0, 1'b0, '0);
    // One active line of display fetches with the host locked out
    h_v = 1'b1; h_we = 1'b0; h_a = 19'd5;
    for (int i = 0; i < 800; i++) step(1'b0, 1'b1, AW'(i));
    step(1'b0, 1'b0, '0);
    h_v = 1'b0;
    step(1'b0, 1'b0, '0);
    // Starvation: a single pulse, then saturation until accepted
    h_v = 1'b1; h_we = 1'b1; h_a = 19'd7; h_wd = 6'b101010;
    for (int i = 0; i < 1100; i++) step(1'b0, 1'b1, AW'($urandom_range(0, 1023)));
    step(1'b0, 1'b0, '0);
    h_we = 1'b0; h_a = 19'd7;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 19'd7);
    step(1'b0, 1'b0, '0);
    h_v = 1'b0;
    // Interleaved display, host read, display
    step(1'b0, 1'b1, 19'h00010);
    h_v = 1'b1; h_we = 1'b0; h_a = 19'd3;
    step(1'b0, 1'b0, '0);
    h_v = 1'b0;
    step(1'b0, 1'b1, 19'd3);
    step(1'b0, 1'b0, '0);
    // Host read then reset: the return must be discarded
    h_v = 1'b1; h_we = 1'b0; h_a = 19'd8;
    step(1'b0, 1'b0, '0);
    h_v = 1'b0;
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    // Randomized traffic over a small address window to force write/read collisions
    for (int i = 0; i < 3000; i++) begin
      if (!h_v && $urandom_range(0, 2) == 0) begin
        h_v = 1'b1; h_we = 1'($urandom); h_a = AW'($urandom_range(0, 63)); h_wd = DW'($urandom);
      end
      step(1'($urandom_range(0, 199) == 0), 1'($urandom), AW'($urandom_range(0, 63)));
      if (acc) h_v = 1'b0;
    end
    h_v = 1'b0;
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
